// File: rtl/spec_register_file.sv
// spec_register_file: A,B,C,D,E,H,L byte registers plus SP, with pair inc/dec/xchg
// and a two-byte pair load sequencer fed from mem_data.
module spec_register_file #(
  parameter int DATA_W = 8,
  parameter logic [2*DATA_W-1:0] SP_INIT = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rd_sel1,
  input  logic [2:0]        rd_sel2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [2:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              alu_wr_a,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [1:0]        pair_sel,
  input  logic [1:0]        pair_op,
  output logic [2*DATA_W-1:0] pair_out,
  input  logic              ld_start,
  input  logic              mem_valid,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, LO, HI} state_t;
  state_t state;
  logic [DATA_W-1:0] r [0:6];
  logic [DATA_W-1:0] nx [0:6];
  logic [2*DATA_W-1:0] sp, nsp, pv;
  logic [1:0] ld_pair;
  assign rd_data1 = rd_sel1 == 3'd7 ? mem_data : r[rd_sel1];
  assign rd_data2 = rd_sel2 == 3'd7 ? DATA_W'(1) : r[rd_sel2];
  assign pair_out = pair_sel == 2'd3 ? sp : {r[{pair_sel, 1'b1}], r[{pair_sel, 1'b1} + 3'd1]};
  assign pv = pair_op == 2'd1 ? pair_out + 1'b1 : pair_out - 1'b1;
  // Later assignments override earlier ones, giving load > pair_op > wr_en > alu per byte.
  always_comb begin
    nx = r;
    nsp = sp;
    if (alu_wr_a) nx[0] = alu_out;
    if (wr_en && wr_sel != 3'd7) nx[wr_sel] = wr_data;
    if (!busy && (pair_op == 2'd1 || pair_op == 2'd2)) begin
      if (pair_sel == 2'd3) nsp = pv;
      else begin
        nx[{pair_sel, 1'b1}] = pv[2*DATA_W-1:DATA_W];
        nx[{pair_sel, 1'b1} + 3'd1] = pv[DATA_W-1:0];
      end
    end
    if (!busy && pair_op == 2'd3) begin
      nx[3] = r[5];
      nx[4] = r[6];
      nx[5] = r[3];
      nx[6] = r[4];
    end
    if (busy && mem_valid) begin
      if (ld_pair == 2'd3) nsp = state == LO ? {sp[2*DATA_W-1:DATA_W], mem_data} : {mem_data, sp[DATA_W-1:0]};
      else if (state == LO) nx[{ld_pair, 1'b1} + 3'd1] = mem_data;
      else nx[{ld_pair, 1'b1}] = mem_data;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '{default: '0};
      sp <= SP_INIT;
      state <= IDLE;
      busy <= 1'b0;
      ld_pair <= 2'd0;
    end else begin
      r <= nx;
      sp <= nsp;
      case (state)
        IDLE: if (ld_start) begin
          ld_pair <= pair_sel;
          state <= LO;
          busy <= 1'b1;
        end
        LO: if (mem_valid) state <= HI;
        HI: if (mem_valid) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/spec_register_file.md
SPEC_REGISTER_FILE -- requirements
Module: spec_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 8, byte width of each register; pair width is 2*DATA_W.
REQ-002 SHALL have parameter SP_INIT, default all-ones (2*DATA_W bits), stack pointer reset value.
REQ-003 SHALL have one clock and one reset, as decided: reset is asynchronous and active-high.
REQ-004 SHALL provide these ports (name  direction  width  meaning):
 - clk  in  1  single clock, rising edge
 - rst  in  1  asynchronous active-high reset
 - rd_sel1  in  3  port-1 select
 - rd_sel2  in  3  port-2 select
 - rd_data1  out  DATA_W  port-1 data
 - rd_data2  out  DATA_W  port-2 data
 - mem_data  in  DATA_W  memory byte: port-1 source and load source
 - wr_en  in  1  byte write strobe
 - wr_sel  in  3  byte write target
 - wr_data  in  DATA_W  byte write data
 - alu_wr_a  in  1  store alu_out into A
 - alu_out  in  DATA_W  ALU result
 - pair_sel  in  2  0=BC, 1=DE, 2=HL, 3=SP
 - pair_op  in  2  0=none, 1=inc, 2=dec, 3=xchg (DE<->HL)
 - pair_out  out  2*DATA_W  selected pair, high byte first
 - ld_start  in  1  start two-byte pair load into pair_sel
 - mem_valid  in  1  mem_data holds the next load byte
 - busy  out  1  pair load in progress

Function
REQ-005 SHALL encode selects as 0=A, 1=B, 2=C, 3=D, 4=E, 5=H, 6=L; code 7 selects mem_data on port 1 and constant 1 on port 2.
REQ-006 SHALL drive rd_data1, rd_data2 and pair_out combinationally from current register state (no write-through).
REQ-007 SHALL write wr_data to register wr_sel on a rising edge with wr_en=1; wr_sel=7 SHALL be ignored.
REQ-008 SHALL write alu_out to A when alu_wr_a=1 and no wr_en write targets A; wr_en SHALL win on A.
REQ-009 SHALL, with pair_op=inc/dec and busy=0, update the pair_sel pair by +1/-1 modulo 2^(2*DATA_W) in one cycle (FFFF+1=0000, 0000-1=FFFF at DATA_W=8).
REQ-010 SHALL, with pair_op=xchg and busy=0, swap D<->H and E<->L in one cycle, ignoring pair_sel.
REQ-011 SHALL implement a load FSM IDLE -> LO -> HI -> IDLE: ld_start in IDLE latches pair_sel, enters LO, sets busy=1 on the next cycle.
REQ-012 SHALL in LO, on mem_valid=1, write mem_data to the low byte and move to HI; in HI, on mem_valid=1, write the high byte and return to IDLE; without mem_valid each state SHALL hold indefinitely.
REQ-013 SHALL keep busy=1 in LO and HI, 0 in IDLE; ld_start while busy SHALL be ignored.
REQ-014 SHALL ignore pair_op while busy=1.
REQ-015 SHALL resolve same-edge conflicts by priority: load byte write > pair_op > wr_en > alu_wr_a; a lower-priority write to a byte claimed by a higher one SHALL be dropped, and writes to other bytes SHALL proceed.
REQ-016 SHALL reach SP only through pair_op inc/dec and the load FSM.

Reset
REQ-017 SHALL, while rst=1, immediately force A,B,C,D,E,H,L to 0, SP to SP_INIT, FSM to IDLE and busy to 0, independent of clk.
REQ-018 SHALL abandon a load in progress on reset; a byte already written SHALL be cleared.
REQ-019 SHALL ignore all write inputs on the first edge after rst falls only if rst is still high at that edge.

Verification
REQ-020 Reset: rst=1 with no clock -> all registers 0, pair_sel=3 gives pair_out=FFFF, busy=0.
REQ-021 Byte write/read: wr B=0x12, C=0x34; rd_sel1=1, rd_sel2=7 -> rd_data1=0x12, rd_data2=0x01; pair_sel=0 -> pair_out=0x1234.
REQ-022 Wrap: HL=0xFFFF, inc -> 0x0000; dec -> 0xFFFF; SP dec from reset -> 0xFFFE.
REQ-023 Load: ld_start with pair_sel=1; mem_valid idle 3 cycles; bytes 0xCD then 0xAB -> busy high throughout, DE=0xABCD, busy low after the HI byte edge; pair_op during busy has no effect.
REQ-024 Conflict: wr_en to A=0x55 with alu_wr_a=1, alu_out=0xAA -> A=0x55; wr_en to H with HL inc on the same edge -> HL incremented, wr_data dropped.
REQ-025 Reset mid-load: rst pulse in HI after low byte -> target pair 0, busy 0, FSM IDLE; next ld_start works normally.
